// File: rtl/riscv_pkg.sv
// Shared types for the register write path.
// Holds the data width, the register address width, and the entry record
// used by the posted-write buffer and its checkers.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the posted-write buffer.
// Walks the valid entries from head (oldest) towards tail (youngest); any
// later match overrides an earlier one, so the youngest pending value wins.
// Ports:
//   i_rd, i_data  entry array (register address / data per slot)
//   i_head        index of the oldest valid entry
//   i_count       number of valid entries
//   i_q_reg       queried register; x0 never hits
//   o_hit, o_data match flag and youngest matching data (0 on miss)
module wb_fwd_match
    import riscv_pkg::reg_addr_t;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  reg_addr_t         i_rd   [DEPTH],
    input  logic [XLEN-1:0]   i_data [DEPTH],
    input  logic [PTR_W-1:0]  i_head,
    input  logic [PTR_W:0]    i_count,
    input  reg_addr_t         i_q_reg,
    output logic              o_hit,
    output logic [XLEN-1:0]   o_data
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PTR_W'(k);
            if ((k < int'(i_count)) && (i_q_reg != '0) && (i_rd[w_idx] == i_q_reg)) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule

// File: rtl/reg_write_buffer.sv
// Posted-write buffer between writeback and the register file write port.
// Accepts results on a valid/ready handshake, queues them in order, drains
// one per cycle into the register file unless stalled, and forwards the
// youngest pending value for two read queries.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_in_valid/o_in_ready        producer handshake
//   i_in_reg, i_in_data          destination register and result
//   i_rf_stall                   register file port unavailable this cycle
//   o_rf_wr_en/_reg/_data        register file write port
//   i_q_reg_*, o_q_hit_*, o_q_data_*  forwarding queries
//   o_count                      occupancy
module reg_write_buffer
    import riscv_pkg::reg_addr_t;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  reg_addr_t               i_in_reg,
    input  logic [XLEN-1:0]         i_in_data,
    input  logic                    i_rf_stall,
    output logic                    o_rf_wr_en,
    output reg_addr_t               o_rf_wr_reg,
    output logic [XLEN-1:0]         o_rf_wr_data,
    input  reg_addr_t               i_q_reg_1,
    input  reg_addr_t               i_q_reg_2,
    output logic                    o_q_hit_1,
    output logic                    o_q_hit_2,
    output logic [XLEN-1:0]         o_q_data_1,
    output logic [XLEN-1:0]         o_q_data_2,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    reg_addr_t         r_rd   [DEPTH];
    logic [XLEN-1:0]   r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_hit_1;
    logic              w_hit_2;
    logic [XLEN-1:0]   w_fdata_1;
    logic [XLEN-1:0]   w_fdata_2;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    // All externally visible state reads as idle while reset is held, so a
    // pending head entry can never reach the register file during reset.
    assign o_in_ready   = i_rst || !w_full;
    assign o_rf_wr_en   = !i_rst && !w_empty && !i_rf_stall;
    assign o_rf_wr_reg  = (!i_rst && !w_empty) ? r_rd[r_head]   : '0;
    assign o_rf_wr_data = (!i_rst && !w_empty) ? r_data[r_head] : '0;
    assign o_count      = r_count;

    // x0 results complete the handshake but are dropped here.
    assign w_push = i_in_valid && !w_full && !i_rst && (i_in_reg != '0);
    assign w_pop  = o_rf_wr_en;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is deliberately not reset; count gates its validity.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_rd[r_tail]   <= i_in_reg;
            r_data[r_tail] <= i_in_data;
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN), .PTR_W(PTR_W)) u_fwd_1 (
        .i_rd    (r_rd),
        .i_data  (r_data),
        .i_head  (r_head),
        .i_count (r_count),
        .i_q_reg (i_q_reg_1),
        .o_hit   (w_hit_1),
        .o_data  (w_fdata_1)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN), .PTR_W(PTR_W)) u_fwd_2 (
        .i_rd    (r_rd),
        .i_data  (r_data),
        .i_head  (r_head),
        .i_count (r_count),
        .i_q_reg (i_q_reg_2),
        .o_hit   (w_hit_2),
        .o_data  (w_fdata_2)
    );

    assign o_q_hit_1  = w_hit_1 && !i_rst;
    assign o_q_hit_2  = w_hit_2 && !i_rst;
    assign o_q_data_1 = i_rst ? '0 : w_fdata_1;
    assign o_q_data_2 = i_rst ? '0 : w_fdata_2;

endmodule

// File: doc/reg_write_buffer.md
# reg_write_buffer

Posted-write buffer sitting between the writeback stage and `register_file`. It is the writer end of the register-file write port. It accepts results through a valid/ready handshake and queues them in a small in-order FIFO. It drains one entry per cycle into the register file's `wr_en`/`wr_reg`/`wr_data` port, except while the port is stalled. It also answers two read-forwarding queries, so the decode stage sees pending values before they land in the register file.

## Interface
- `DEPTH`, 4: number of buffer entries; a power of two, ≥2.
- `XLEN`, 32: data width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has a result.
- `in_ready`  out  1  buffer can accept; equals `count != DEPTH`.
- `in_reg`  in  5  destination register.
- `in_data`  in  XLEN  result data.
- `rf_stall`  in  1  register-file write port unavailable this cycle.
- `rf_wr_en`  out  1  to `register_file.wr_en`.
- `rf_wr_reg`  out  5  to `register_file.wr_reg`.
- `rf_wr_data`  out  XLEN  to `register_file.wr_data`.
- `q_reg_1`, `q_reg_2`  in  5  forwarding query addresses, tied to `rd_reg_1`/`rd_reg_2`.
- `q_hit_1`, `q_hit_2`  out  1  a pending entry exists for the queried register.
- `q_data_1`, `q_data_2`  out  XLEN  data of the youngest matching pending entry.
- `count`  out  $clog2(DEPTH)+1  occupancy.

## Operation
- **Push:** happens at a rising edge where `in_valid && in_ready`. The entry is written at the tail and the tail pointer increments modulo DEPTH.
- **x0 writes:** a push with `in_reg == 0` is accepted (handshake completes) but nothing is stored, and `count` does not change.
- **Pop:** happens at a rising edge where `rf_wr_en` is 1.
  - `rf_wr_en = (count != 0) && !rf_stall`, combinational.
  - `rf_wr_reg`/`rf_wr_data` are combinational from the head entry, and drive 0 when empty.
- **Simultaneous push and pop:** both take effect and `count` is unchanged.
- **Full:** `in_ready` is 0. There is no same-cycle bypass of a full buffer, even if a pop occurs.
- **Ordering:** strictly FIFO. Two pending writes to the same register drain oldest first.
- **Forwarding, per query port:**
  - `q_hit` is 1 when some valid entry has `reg == q_reg` and `q_reg != 0`.
  - `q_data` comes from the youngest such entry (closest to the tail).
  - The head entry being popped this cycle still counts as a hit, because the register file updates only at that edge.
  - `in_data` of a not-yet-accepted push is never forwarded.
  - With no hit, `q_data = 0`.
- **Stall:** while `rf_stall` is 1, no pop occurs; contents and forwarding are unaffected.

## Timing
- **Latency:** an entry pushed at edge N with `rf_stall` low is at the head in cycle N+1. `rf_wr_en` is asserted in that cycle, and `register_file` holds the value after edge N+1. Forwarding hits from cycle N+1 through edge N+1.
- **Throughput:** one push and one pop per cycle.
- **Reset:** while `rst` is 1 at an edge:
  - pointers and `count` clear to 0;
  - `rf_wr_en=0`, `rf_wr_reg=0`, `rf_wr_data=0`, `in_ready=1`, `q_hit_*=0`, `q_data_*=0`;
  - entry storage is not cleared.
- **Reset mid-operation:** reset wins over a simultaneous push or pop. Pending entries are discarded and never written.
- **Pointer wrap:** pointers wrap modulo DEPTH. `count` distinguishes full from empty.

## Structure
- **`riscv_pkg` additions:**
  - `XLEN`;
  - `REG_ADDR_W = 5`;
  - typedef `reg_addr_t`;
  - typedef struct `wb_entry_t {reg_addr_t rd; logic [XLEN-1:0] data;}`.
- **Sub-module `wb_fwd_match`:** combinational youngest-match priority search over the entry array, given head, count and a query address. It is instantiated twice, once per query port.
- **Top level:** storage, pointers, count and handshake logic stay in `reg_write_buffer`.

## Test plan
- **Reset state:** reset, then idle → `count=0`, `in_ready=1`, `rf_wr_en=0`, `q_hit_1=0` for `q_reg_1=5`.
- **Single write:** push x5=0xDEADBEEF with `rf_stall=0` → next cycle `rf_wr_en=1`, `rf_wr_reg=5`, `q_hit_1=1`, `q_data_1=0xDEADBEEF`. After the following edge, `count=0` and `register_file` reads 0xDEADBEEF at x5.
- **Full and ordering:** hold `rf_stall=1`, push x15=0xFFFF0000, x15=0x0000FFFF, x3=1, x4=2 →
  - `count=4`, `in_ready=0`;
  - `q_reg_2=15` gives `q_data_2=0x0000FFFF`;
  - after releasing the stall, writes drain in order x15, x15, x3, x4, one per cycle.
- **x0 write:** push x0=0xFFFFFFFF → handshake completes, `count` stays 0, `rf_wr_en` never asserts, `q_hit` is 0 for `q_reg=0`.
- **Simultaneous push and pop:** with `count=2`, push x7=9 while popping → `count` stays 2. After reset is asserted mid-drain, `count=0` and no further `rf_wr_en` appears.
- **Random:** 10000 cycles of random `in_valid`/`in_reg`/`in_data`/`rf_stall` against a reference register-file model and queue model. Checks:
  - every `q_hit`/`q_data`;
  - every `rf_wr_*`;
  - final register contents.
